iot_byte_serializer: RTL and testbench
======================================

# iot_byte_serializer

Upstream feeder for the IoT data filter (IOTDF). It accepts 128-bit sensor words over a valid/ready handshake, buffers up to two words, and serializes each word MSB-byte-first onto the filter's 8-bit `iot_in`/`in_en` input, stalling whenever the filter asserts `busy`. It also tracks 8-word rounds, the unit the filter functions operate on, and flags each round's completion.

## Interface

- `ROUND_WORDS`, 8: words per filter round; sets `round_done` and `word_idx` wrap.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  buffer can accept a word.
- `s_data`  in  128  upstream word; byte 0 = `s_data[127:120]`.
- `busy`  in  1  from IOTDF; filter cannot take a byte.
- `in_en`  out  1  to IOTDF; `iot_in` carries a valid byte this cycle.
- `iot_in`  out  8  to IOTDF; serialized byte.
- `word_idx`  out  3  index of the word currently being sent within its round (0..ROUND_WORDS-1).
- `round_done`  out  1  one-cycle pulse after the last byte of a round's last word.
- `idle`  out  1  buffer empty and no byte in flight.

## Operation

- 2-entry FIFO (wr_ptr, rd_ptr, count 0..2). Push when `s_valid && s_ready`. `s_ready = (count != 2)`, combinational from registered count; no same-cycle bypass when full.
- Byte counter `bidx` (4 bits) selects `head[127-8*bidx -: 8]`.
- Each posedge, with `count != 0` and `busy == 0`: register `iot_in <= selected byte`, `in_en <= 1`, `bidx <= bidx+1`. When `bidx == 15`: pop head, `bidx <= 0`, and advance `word_idx` mod ROUND_WORDS.
- Otherwise (busy high or FIFO empty): `in_en <= 0`, `iot_in <= 8'h00`; `bidx`/head hold. A byte is never skipped or repeated across a stall.
- Pop and push in the same cycle are allowed; count is unchanged.
- `round_done <= 1` on the same edge that issues byte 15 of the word with `word_idx == ROUND_WORDS-1`. It is visible in the cycle `in_en` carries that byte, and is 0 otherwise.
- `idle = (count == 0) && !in_en`.
- States are implicit in (count, bidx): EMPTY (count 0), SEND (count > 0), STALL (count > 0, busy).

## Timing

- Reset values: `s_ready=1`, `in_en=0`, `iot_in=0`, `word_idx=0`, `round_done=0`, `idle=1`, and count, bidx and pointers all 0.
- Latency: word accepted at edge T0 gives byte 0 with `in_en=1` after edge T1, if `busy` was low at T1.
- Throughput: 1 byte/cycle, 16 cycles/word. Back-to-back words have no bubble when the FIFO holds the next word.
- `busy` is sampled at the posedge. A byte already driven when `busy` rises is considered delivered.
- Reset mid-word: the partial word and the buffered words are discarded, and `word_idx` returns to 0.
- Wrap: `bidx` 15→0 and `word_idx` (ROUND_WORDS-1)→0 without glitch.

## Configuration

- `IOT_SER_STAT_EN` defined: adds output `words_sent[15:0]`, reset 0. It increments on every pop and wraps at 16'hFFFF→0.
- Without it: the port and counter are absent. All other behaviour is identical.

## Test plan

- Single word 128'h00112233_44556677_8899AABB_CCDDEEFF, `busy=0`: `in_en` high for 16 consecutive cycles with bytes 00,11,…,FF, then `idle=1`.
- Two words pushed back-to-back: 32 contiguous `in_en` cycles. `s_ready` drops when count=2 and rises the cycle after the first pop.
- `busy` high for 3 cycles after byte 5 of a word: `in_en=0` for those 3 cycles, then byte 6 follows. No byte is lost or duplicated.
- 8 words streamed: `word_idx` steps 0..7, and `round_done` pulses once with byte FF of word 7. A 9th word starts at `word_idx=0`.
- `rst` asserted at byte 9 with one word queued: `in_en=0` immediately, `s_ready=1`. After release, a new word starts from byte 0.
- With `IOT_SER_STAT_EN`: 96 words sent gives `words_sent=96`.

Source files
------------

// File: rtl/iot_byte_serializer_if.sv
// Word handshake from the sensor side plus the byte lane into the IOTDF filter.
// The slave modport is the serializer's view; master is the side that feeds words and drives busy.
interface iot_byte_serializer_if;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         busy;
  logic         in_en;
  logic [7:0]   iot_in;

  modport master (
    output s_valid,
    output s_data,
    output busy,
    input  s_ready,
    input  in_en,
    input  iot_in
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  busy,
    output s_ready,
    output in_en,
    output iot_in
  );
endinterface

// File: rtl/iot_byte_serializer.sv
// Two-word buffer that serializes 128-bit words MSB byte first into IOTDF: first byte one cycle after acceptance,
// holds while busy, s_ready low only when both entries are occupied. Define IOT_SER_STAT_EN to add the words_sent counter.
module iot_byte_serializer #(
  parameter int ROUND_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  iot_byte_serializer_if.slave     sif,
  output logic [2:0]               word_idx,
  output logic                     round_done,
  output logic                     idle
`ifdef IOT_SER_STAT_EN
  ,
  output logic [15:0]              words_sent
`endif
);

  logic [127:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [3:0]   bidx;
  logic         in_en_q;
  logic [7:0]   iot_in_q;

  logic         push;
  logic         send;
  logic         pop;
  logic         last_word;
  logic [127:0] head;
  logic [6:0]   byte_msb;
  logic [7:0]   cur_byte;

  assign sif.s_ready = (count != 2'd2);
  assign push        = sif.s_valid && sif.s_ready;
  assign send        = (count != 2'd0) && !sif.busy;
  assign pop         = send && (bidx == 4'hF);
  assign last_word   = (word_idx == 3'(ROUND_WORDS - 1));

  // Byte bidx of the head word lives at bits [127-8*bidx -: 8].
  assign head     = mem[rd_ptr];
  assign byte_msb = 7'd127 - {bidx, 3'b000};
  assign cur_byte = head[byte_msb -: 8];

  assign sif.in_en  = in_en_q;
  assign sif.iot_in = iot_in_q;
  assign idle       = (count == 2'd0) && !in_en_q;

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sif.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A stall leaves bidx and the head untouched, so the next byte resumes exactly where it stopped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bidx       <= 4'd0;
      in_en_q    <= 1'b0;
      iot_in_q   <= 8'h00;
      word_idx   <= 3'd0;
      round_done <= 1'b0;
    end else begin
      round_done <= 1'b0;
      if (send) begin
        in_en_q  <= 1'b1;
        iot_in_q <= cur_byte;
        bidx     <= bidx + 4'd1;
        if (pop) begin
          round_done <= last_word;
          word_idx   <= last_word ? 3'd0 : word_idx + 3'd1;
        end
      end else begin
        in_en_q  <= 1'b0;
        iot_in_q <= 8'h00;
      end
    end
  end

`ifdef IOT_SER_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_sent <= 16'd0;
    end else if (pop) begin
      words_sent <= words_sent + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iot_byte_serializer.sv
// Randomized and directed bench for iot_byte_serializer against a byte-queue reference model.
module tb_iot_byte_serializer;
  localparam int RW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  word_idx;
  logic        round_done;
  logic        idle;
`ifdef IOT_SER_STAT_EN
  logic [15:0] words_sent;
`endif

  iot_byte_serializer_if tif();

  iot_byte_serializer #(.ROUND_WORDS(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sif        (tif),
    .word_idx   (word_idx),
    .round_done (round_done),
    .idle       (idle)
`ifdef IOT_SER_STAT_EN
    ,
    .words_sent (words_sent)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: every accepted word becomes 16 bytes in a queue; one byte leaves per non-busy cycle.
  logic [7:0] pend[$];
  bit         m_en   = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_wi   = 0;
  bit         m_rd   = 1'b0;
  logic [15:0] m_sent = 16'd0;
  int         m_words;
  bit         m_rdy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
      m_en   = 1'b0;
      m_byte = 8'h00;
      m_wi   = 0;
      m_rd   = 1'b0;
      m_sent = 16'd0;
    end else begin
      m_words = (pend.size() + 15) / 16;
      m_rdy   = (m_words != 2);
      m_rd    = 1'b0;
      if (pend.size() != 0 && !tif.busy) begin
        m_en   = 1'b1;
        m_byte = pend.pop_front();
        if (pend.size() % 16 == 0) begin
          m_sent = m_sent + 16'd1;
          m_rd   = (m_wi == RW - 1);
          m_wi   = (m_wi + 1) % RW;
        end
      end else begin
        m_en   = 1'b0;
        m_byte = 8'h00;
      end
      if (tif.s_valid && m_rdy) begin
        for (int i = 0; i < 16; i++) pend.push_back(tif.s_data[127-8*i -: 8]);
      end
    end
  end

  // Capture of delivered bytes for the directed literal checks.
  int          cyc = 0;
  int          nrdy_lo = 0;
  logic [7:0]  cap[$];
  int          cap_cyc[$];
  logic [2:0]  cap_wi[$];
  bit          cap_rd[$];

  always @(negedge clk) begin
    cyc++;
    chk("in_en", tif.in_en, m_en);
    chk("iot_in", tif.iot_in, m_byte);
    chk("s_ready", tif.s_ready, ((pend.size() + 15) / 16) != 2);
    chk("word_idx", word_idx, m_wi);
    chk("round_done", round_done, m_rd);
    chk("idle", idle, (pend.size() == 0) && !m_en);
`ifdef IOT_SER_STAT_EN
    chk("words_sent", words_sent, m_sent);
`endif
    if (tif.in_en) begin
      cap.push_back(tif.iot_in);
      cap_cyc.push_back(cyc);
      cap_wi.push_back(word_idx);
      cap_rd.push_back(round_done);
    end
    if (!tif.s_ready) nrdy_lo++;
  end

  task automatic push(input logic [127:0] w);
    int n = 0;
    tif.s_valid = 1'b1;
    tif.s_data  = w;
    while (!tif.s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("push_timeout", 1, 0);
    @(negedge clk);
    tif.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(idle && pend.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_byte(input logic [7:0] b);
    int n = 0;
    while (!(tif.in_en && tif.iot_in == b) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("byte_timeout", 1, 0);
  endtask

  task automatic clear_cap();
    cap.delete();
    cap_cyc.delete();
    cap_wi.delete();
    cap_rd.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  logic [127:0] pat;
  logic [127:0] w;
  bit           stop_busy;
  int           rd_cnt;

  initial begin
    tif.s_valid = 1'b0;
    tif.s_data  = '0;
    tif.busy    = 1'b0;
    pat = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Single word, no backpressure.
    clear_cap();
    push(pat);
    wait_idle();
    chk("t1_len", cap.size(), 16);
    for (int i = 0; i < 16; i++) chk("t1_byte", cap[i], 8'(8'h11 * i));
    chk("t1_contig", cap_cyc[15] - cap_cyc[0], 15);

    // Two back-to-back words: 32 contiguous bytes, s_ready low for 15 cycles.
    clear_cap();
    nrdy_lo = 0;
    push({$urandom, $urandom, $urandom, $urandom});
    push({$urandom, $urandom, $urandom, $urandom});
    wait_idle();
    chk("t2_len", cap.size(), 32);
    chk("t2_contig", cap_cyc[31] - cap_cyc[0], 31);
    chk("t2_ready_low", nrdy_lo, 15);

    // Three busy cycles after byte 5.
    clear_cap();
    tif.s_valid = 1'b1;
    tif.s_data  = pat;
    @(negedge clk);
    tif.s_valid = 1'b0;
    wait_byte(8'h55);
    tif.busy = 1'b1;
    repeat (3) @(negedge clk);
    tif.busy = 1'b0;
    wait_idle();
    chk("t3_len", cap.size(), 16);
    chk("t3_gap", cap_cyc[6] - cap_cyc[5], 4);
    chk("t3_b5", cap[5], 8'h55);
    chk("t3_b6", cap[6], 8'h66);

    // Reset at byte 9 with a second word queued.
    push(pat);
    push({$urandom, $urandom, $urandom, $urandom});
    wait_byte(8'h99);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_in_en", tif.in_en, 0);
    chk("t5_s_ready", tif.s_ready, 1);
    chk("t5_word_idx", word_idx, 0);
    chk("t5_idle", idle, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    clear_cap();
    w = {$urandom, $urandom, $urandom, $urandom};
    push(w);
    wait_idle();
    chk("t5_len", cap.size(), 16);
    chk("t5_first", cap[0], w[127:120]);

    // Nine words from a fresh round: one round_done, on byte 127, word_idx wraps.
    do_reset();
    clear_cap();
    for (int k = 0; k < 9; k++) push({$urandom, $urandom, $urandom, $urandom});
    wait_idle();
    chk("t4_len", cap.size(), 144);
    rd_cnt = 0;
    foreach (cap_rd[i]) if (cap_rd[i]) rd_cnt++;
    chk("t4_rd_count", rd_cnt, 1);
    chk("t4_rd_pos", cap_rd[127], 1);
    chk("t4_wi_wrap", cap_wi[127], 0);
    for (int k = 0; k < 9; k++) chk("t4_wi", cap_wi[16*k], k % RW);

    // Randomized: 96 words, random gaps and random busy.
    do_reset();
    stop_busy = 1'b0;
    fork
      begin
        for (int k = 0; k < 96; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push({$urandom, $urandom, $urandom, $urandom});
        end
        stop_busy = 1'b1;
      end
      begin
        while (!stop_busy) begin
          @(negedge clk);
          tif.busy = ($urandom_range(0, 3) == 0);
        end
        tif.busy = 1'b0;
      end
    join
    wait_idle();
    chk("rand_model_sent", m_sent, 96);
`ifdef IOT_SER_STAT_EN
    chk("rand_words_sent", words_sent, 96);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
